// File: rtl/sat_counter_bank.sv
// Bank of independent saturating up/down counters with load, clear, sticky goal and ovf/unf pulses.
// Latency: 1 clk from increase/decrease/load/clear to value and pulses; at_zero/at_max are combinational on value.
// Backpressure: none; every channel accepts an update every cycle.
module sat_counter_bank #(
    parameter int              WIDTH      = 20,
    parameter int              N_CH       = 2,
    parameter logic [WIDTH-1:0] MAX_VAL   = {WIDTH{1'b1}},
    parameter int              UNDER_MODE = 0
) (
    input  logic                  clk,
    input  logic                  resetN,
    input  logic [N_CH*WIDTH-1:0] increase,
    input  logic [N_CH*WIDTH-1:0] decrease,
    input  logic [N_CH-1:0]       load,
    input  logic [N_CH*WIDTH-1:0] load_value,
    input  logic [N_CH-1:0]       clear,
    input  logic [WIDTH-1:0]      target,
    output logic [N_CH*WIDTH-1:0] value,
    output logic [N_CH-1:0]       at_zero,
    output logic [N_CH-1:0]       at_max,
    output logic [N_CH-1:0]       ovf_pulse,
    output logic [N_CH-1:0]       unf_pulse,
    output logic [N_CH-1:0]       goal
);

    localparam int SW = WIDTH + 2;
    typedef logic signed [SW-1:0] sum_t;

    localparam sum_t MAX_S = $signed({2'b00, MAX_VAL});

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        logic [WIDTH-1:0] cnt;
        logic [WIDTH-1:0] inc;
        logic [WIDTH-1:0] dec;
        logic [WIDTH-1:0] ldv;
        logic [WIDTH-1:0] cnt_nxt;
        logic             ovf_nxt;
        logic             unf_nxt;
        logic             goal_nxt;
        logic             goal_q;
        logic             ovf_q;
        logic             unf_q;
        sum_t             sum;

        assign inc = increase[i*WIDTH +: WIDTH];
        assign dec = decrease[i*WIDTH +: WIDTH];
        assign ldv = load_value[i*WIDTH +: WIDTH];

        // Two guard bits keep value+increase-decrease exact before the bounds check.
        assign sum = $signed({2'b00, cnt}) + $signed({2'b00, inc}) - $signed({2'b00, dec});

        always_comb begin
            cnt_nxt  = cnt;
            ovf_nxt  = 1'b0;
            unf_nxt  = 1'b0;
            goal_nxt = goal_q;
            if (clear[i]) begin
                cnt_nxt  = '0;
                goal_nxt = 1'b0;
            end else if (load[i]) begin
                if (ldv > MAX_VAL) begin
                    cnt_nxt = MAX_VAL;
                    ovf_nxt = 1'b1;
                end else begin
                    cnt_nxt = ldv;
                end
                goal_nxt = (cnt_nxt >= target);
            end else begin
                if (inc != '0 || dec != '0) begin
                    if (sum > MAX_S) begin
                        cnt_nxt = MAX_VAL;
                        ovf_nxt = 1'b1;
                    end else if (sum < 0) begin
                        unf_nxt = 1'b1;
                        if (UNDER_MODE == 0) cnt_nxt = '0;
                    end else begin
                        cnt_nxt = sum[WIDTH-1:0];
                    end
                end
                // Sticky: only clear, load or reset drop it, never a target change.
                goal_nxt = goal_q | (cnt_nxt >= target);
            end
        end

        always_ff @(posedge clk or negedge resetN) begin
            if (!resetN) begin
                cnt    <= '0;
                ovf_q  <= 1'b0;
                unf_q  <= 1'b0;
                goal_q <= 1'b0;
            end else begin
                cnt    <= cnt_nxt;
                ovf_q  <= ovf_nxt;
                unf_q  <= unf_nxt;
                goal_q <= goal_nxt;
            end
        end

        assign value[i*WIDTH +: WIDTH] = cnt;
        assign at_zero[i]   = (cnt == '0);
        assign at_max[i]    = (cnt == MAX_VAL);
        assign ovf_pulse[i] = ovf_q;
        assign unf_pulse[i] = unf_q;
        assign goal[i]      = goal_q;
    end

endmodule

// File: tb/tb_sat_counter_bank.sv
// Directed bench: two banks (clamp and reject underflow policy) on shared stimulus, WIDTH=8, MAX_VAL=200.
module tb_sat_counter_bank;

    logic        clk = 1'b0;
    logic        resetN;
    logic [15:0] increase;
    logic [15:0] decrease;
    logic [1:0]  load;
    logic [15:0] load_value;
    logic [1:0]  clear;
    logic [7:0]  target;

    logic [15:0] value0, value1;
    logic [1:0]  at_zero0, at_zero1, at_max0, at_max1;
    logic [1:0]  ovf0, ovf1, unf0, unf1, goal0, goal1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sat_counter_bank #(.WIDTH(8), .N_CH(2), .MAX_VAL(8'd200), .UNDER_MODE(0)) u_clamp (
        .clk(clk), .resetN(resetN), .increase(increase), .decrease(decrease),
        .load(load), .load_value(load_value), .clear(clear), .target(target),
        .value(value0), .at_zero(at_zero0), .at_max(at_max0),
        .ovf_pulse(ovf0), .unf_pulse(unf0), .goal(goal0)
    );

    sat_counter_bank #(.WIDTH(8), .N_CH(2), .MAX_VAL(8'd200), .UNDER_MODE(1)) u_reject (
        .clk(clk), .resetN(resetN), .increase(increase), .decrease(decrease),
        .load(load), .load_value(load_value), .clear(clear), .target(target),
        .value(value1), .at_zero(at_zero1), .at_max(at_max1),
        .ovf_pulse(ovf1), .unf_pulse(unf1), .goal(goal1)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic idle();
        increase   = '0;
        decrease   = '0;
        load       = '0;
        load_value = '0;
        clear      = '0;
    endtask

    // Advance one edge and settle; inputs are driven and outputs sampled 1 ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load_ch0(input logic [7:0] v);
        idle();
        load       = 2'b01;
        load_value = {8'd0, v};
        step();
        idle();
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        idle();
        target = 8'd255;
        resetN = 1'b0;
        #12;
        check("rst_value", value0, 0);
        check("rst_at_zero", at_zero0, 2'b11);
        check("rst_at_max", at_max0, 0);
        check("rst_pulses", {ovf0, unf0, goal0}, 0);
        #2;
        resetN = 1'b1;
        step();

        // Overflow saturates at MAX_VAL with a single-cycle pulse.
        load_ch0(8'd190);
        check("load190", value0[7:0], 190);
        increase = 16'd20;
        step();
        idle();
        check("ovf_value", value0[7:0], 200);
        check("ovf_pulse", ovf0, 2'b01);
        check("ovf_at_max", at_max0, 2'b01);
        check("ovf_ch1_iso", value0[15:8], 0);
        step();
        check("ovf_pulse_end", ovf0, 0);
        check("ovf_hold", value0[7:0], 200);

        // Landing exactly on MAX_VAL is not an overflow.
        load_ch0(8'd190);
        increase = 16'd10;
        step();
        idle();
        check("exact_max", value0[7:0], 200);
        check("exact_max_flag", at_max0, 2'b01);
        check("exact_no_ovf", ovf0, 0);

        // Load above MAX_VAL clamps and reports overflow.
        load_ch0(8'd250);
        check("load_clamp", value0[7:0], 200);
        check("load_ovf", ovf0, 2'b01);

        // Underflow: clamp vs reject policy.
        load_ch0(8'd5);
        decrease = 16'd9;
        step();
        idle();
        check("unf_clamp_val", value0[7:0], 0);
        check("unf_clamp_pulse", unf0, 2'b01);
        check("unf_clamp_zero", at_zero0, 2'b11);
        check("unf_reject_val", value1[7:0], 5);
        check("unf_reject_pulse", unf1, 2'b01);
        check("unf_no_ovf", {ovf0, ovf1}, 0);
        step();
        check("unf_pulse_end", {unf0, unf1}, 0);

        // Netted update lands exactly on zero: no pulse.
        load_ch0(8'd10);
        increase = 16'd3;
        decrease = 16'd13;
        step();
        idle();
        check("net_val", {value1[7:0], value0[7:0]}, 0);
        check("net_pulses", {ovf0, unf0, ovf1, unf1}, 0);
        load_ch0(8'd77);
        clear      = 2'b01;
        load       = 2'b01;
        load_value = 16'd50;
        step();
        idle();
        check("clear_wins", value0[7:0], 0);
        check("clear_no_pulse", {ovf0, unf0}, 0);

        // Sticky goal.
        target   = 8'd100;
        increase = 16'd40;
        step();
        check("goal_40", {value0[7:0], 6'd0, goal0}, {8'd40, 8'd0});
        step();
        check("goal_80", {value0[7:0], 6'd0, goal0}, {8'd80, 8'd0});
        step();
        idle();
        check("goal_120", {value0[7:0], 6'd0, goal0}, {8'd120, 8'd1});
        target = 8'd250;
        step();
        check("goal_sticky", goal0, 2'b01);
        clear = 2'b01;
        step();
        idle();
        check("goal_cleared", goal0, 0);
        check("goal_clear_val", value0[7:0], 0);

        // Channel independence.
        increase = 16'h0007;
        decrease = 16'h0300;
        step();
        idle();
        check("iso_clamp_val", value0, 16'h0007);
        check("iso_clamp_pulse", {ovf0, unf0}, {2'b00, 2'b10});
        check("iso_reject_val", value1, 16'h0007);
        check("iso_reject_pulse", {ovf1, unf1}, {2'b00, 2'b10});

        // Async reset between edges discards state; first edge after release applies.
        target     = 8'd100;
        load       = 2'b10;
        load_value = 16'h9600;
        step();
        idle();
        check("pre_rst_goal", goal0, 2'b10);
        increase = 16'd5;
        #2;
        resetN = 1'b0;
        #1;
        check("arst_value", {value1, value0}, 0);
        check("arst_flags", {goal0, ovf0, unf0, at_max0}, 0);
        check("arst_zero", at_zero0, 2'b11);
        #1;
        resetN = 1'b1;
        step();
        idle();
        check("post_rst_update", value0, 16'd5);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
